// File: rtl/audio_pkg.sv
// Shared types and constants for the tone sequencer: note-entry layout,
// FSM state encoding, default amplitude and the default melody table.
package audio_pkg;

  localparam int NOTE_W    = 27;
  localparam int HP_W      = 19;
  localparam int DUR_W     = 8;
  localparam int ROM_DEPTH = 16;
  localparam int IDX_W     = 4;

  localparam logic [31:0] DEF_AMPLITUDE = 32'd10000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Packs one table entry as {half_period, duration}.
  function automatic logic [NOTE_W-1:0] note_pack(input logic [HP_W-1:0]  hp,
                                                  input logic [DUR_W-1:0] dur);
    return {hp, dur};
  endfunction

  // C-major scale, C4 up to C5 at 50 MHz (half period = 25e6 / f),
  // 400 ms per note. Entry 0 sits in the least significant slot.
  localparam logic [ROM_DEPTH*NOTE_W-1:0] MELODY = {
    {(8*NOTE_W){1'b0}},
    note_pack(19'd47778, 8'd4),  // C5
    note_pack(19'd50619, 8'd4),  // B4
    note_pack(19'd56818, 8'd4),  // A4
    note_pack(19'd63776, 8'd4),  // G4
    note_pack(19'd71586, 8'd4),  // F4
    note_pack(19'd75843, 8'd4),  // E4
    note_pack(19'd85131, 8'd4),  // D4
    note_pack(19'd95556, 8'd4)   // C4
  };

endpackage

// File: rtl/note_rom.sv
// 16-entry note table with a registered read port (one cycle of latency).
module note_rom
  import audio_pkg::*;
#(
  parameter logic [ROM_DEPTH*NOTE_W-1:0] CONTENTS = MELODY
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  addr,
  output logic [NOTE_W-1:0] data
);

  // Registered table lookup.
  // NOTE: the read register has no reset; it is reloaded on every edge and
  // is only consumed a full cycle after the address has settled.
  always_ff @(posedge clk) begin
    data <= CONTENTS[addr*NOTE_W +: NOTE_W];
  end

endmodule

// File: rtl/audio_tone_sequencer.sv
// Melody player: walks the note table (fetch, play, gap), generates a
// square wave while a note plays and mixes it with the microphone samples
// on the Audio_Controller handshake.
module audio_tone_sequencer
  import audio_pkg::*;
#(
  parameter int                          NUM_NOTES  = 8,
  parameter int                          DUR_UNIT   = 5_000_000,
  parameter int                          GAP_CYCLES = 500_000,
  parameter logic [31:0]                 AMPLITUDE  = DEF_AMPLITUDE,
  parameter logic [ROM_DEPTH*NOTE_W-1:0] ROM_INIT   = MELODY
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             start,
  input  logic             stop,
  input  logic             mic_enable,
  input  logic             audio_in_available,
  input  logic             audio_out_allowed,
  input  logic [31:0]      left_channel_audio_in,
  input  logic [31:0]      right_channel_audio_in,
  output logic             read_audio_in,
  output logic             write_audio_out,
  output logic [31:0]      left_channel_audio_out,
  output logic [31:0]      right_channel_audio_out,
  output logic             busy,
  output logic [IDX_W-1:0] note_index,
  output logic             done
);

  localparam int TICK_MAX = (DUR_UNIT > GAP_CYCLES) ? DUR_UNIT : GAP_CYCLES;
  localparam int TICK_W   = $clog2(TICK_MAX + 1);

  localparam logic [TICK_W-1:0] UNIT_LAST = TICK_W'(DUR_UNIT - 1);
  localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_NOTE = IDX_W'(NUM_NOTES - 1);

  state_t              state;
  logic [NOTE_W-1:0]   note;
  logic [HP_W-1:0]     half_period;
  logic [DUR_W-1:0]    duration;
  logic [DUR_W-1:0]    dur_len;
  logic [HP_W-1:0]     hp_cnt;
  logic [DUR_W-1:0]    unit_cnt;
  logic [TICK_W-1:0]   tick;
  logic                snd;
  logic [31:0]         sound;

  // The ROM is addressed by note_index, which is stable from FETCH until
  // the end of GAP, so its output register captures the note on PLAY entry
  // and holds it for the whole note.
  note_rom #(.CONTENTS(ROM_INIT)) u_note_rom (
    .clk  (CLOCK_50),
    .addr (note_index),
    .data (note)
  );

  assign {half_period, duration} = note;
  assign dur_len = (duration == '0) ? DUR_W'(1) : duration;

  // Sequencer FSM plus tone and duration counters; stop acts as a soft reset.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block samples the pre-edge values of the others.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn || stop) begin
      state      <= IDLE;
      note_index <= '0;
      hp_cnt     <= '0;
      unit_cnt   <= '0;
      tick       <= '0;
      snd        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          state    <= PLAY;
          hp_cnt   <= '0;
          snd      <= 1'b0;
          unit_cnt <= '0;
          tick     <= '0;
        end
        PLAY: begin
          if (hp_cnt == half_period) begin
            hp_cnt <= '0;
            snd    <= ~snd;
          end else begin
            hp_cnt <= hp_cnt + 1'b1;
          end
          if (tick == UNIT_LAST) begin
            tick <= '0;
            if (unit_cnt == dur_len - 1'b1) begin
              unit_cnt <= '0;
              state    <= GAP;
            end else begin
              unit_cnt <= unit_cnt + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        GAP: begin
          if (tick == GAP_LAST) begin
            tick <= '0;
            if (note_index == LAST_NOTE) begin
              state      <= IDLE;
              note_index <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              state      <= FETCH;
              note_index <= note_index + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Square-wave sample: silent outside PLAY and for rests.
  // NOTE: the default assignment comes first so no path leaves sound
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sound = '0;
    if (state == PLAY && half_period != '0) begin
      sound = snd ? AMPLITUDE : (32'd0 - AMPLITUDE);
    end
  end

  assign read_audio_in   = audio_in_available & audio_out_allowed;
  assign write_audio_out = audio_in_available & audio_out_allowed;

  assign left_channel_audio_out  = (mic_enable ? left_channel_audio_in  : 32'd0) + sound;
  assign right_channel_audio_out = (mic_enable ? right_channel_audio_in : 32'd0) + sound;

endmodule
